// File: rtl/uart_rx_deser.sv
// uart_rx_deser: 16x-oversampled UART receiver with 3-sample majority vote, LSB-first deserializer
// and valid/ack output handshake. Define UART_RX_PARITY_EN to add a parity bit (sense: PARITY_ODD).
module uart_rx_deser #(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2,
    parameter bit PARITY_ODD  = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_rx,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ack,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 parity_err,
    output logic                 busy
);
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [3:0]             cnt_q, cnt_d;
    logic [2:0]             bit_q, bit_d;
    logic [2:0]             vote_q, vote_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   done_q, done_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;
    logic                   ovr_q, ovr_d;
    logic                   rxs, maj_now, load;
    logic [2:0]             vote_sh;

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

    assign rxs     = sync_q[SYNC_STAGES-1];
    // History including this tick's sample: at index 8 this holds samples 6, 7 and 8.
    assign vote_sh = {vote_q[1:0], rxs};
    assign maj_now = maj3(vote_sh);
    assign load    = done_q && (!valid_q || rx_ack);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_q <= '1;
        else      sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        vote_d  = vote_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        if (en_rx) begin
            vote_d = vote_sh;
            cnt_d  = cnt_q + 4'd1;
            unique case (state_q)
                S_IDLE: begin
                    cnt_d = 4'd0;
                    if (!rxs) state_d = S_START;
                end
                S_START: begin
                    if (cnt_q == 4'd8 && maj_now) begin
                        state_d = S_IDLE;
                    end else if (cnt_q == 4'd15) begin
                        state_d = S_DATA;
                        bit_d   = 3'd0;
                    end
                end
                S_DATA: begin
                    if (cnt_q == 4'd8) begin
                        shift_d[bit_q] = maj_now;
                    end else if (cnt_q == 4'd15) begin
                        if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (cnt_q == 4'd15) state_d = S_STOP;
                end
`endif
                S_STOP: begin
                    // Leaving at mid-stop lets the next start edge be caught early.
                    if (cnt_q == 4'd8) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // The stop-bit vote is read from vote_q in the clk after the index-8 tick, when it holds 6..8.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = ferr_q;
        ovr_d   = ovr_q;
        if (load) begin
            data_d  = shift_q;
            ferr_d  = ~maj3(vote_q);
            valid_d = 1'b1;
            if (rx_ack) ovr_d = 1'b0;
        end else if (done_q) begin
            ovr_d = 1'b1;
        end else if (rx_ack && valid_q) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            bit_q   <= 3'd0;
            vote_q  <= 3'b111;
            shift_q <= '0;
            done_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            vote_q  <= vote_d;
            shift_q <= shift_d;
            done_q  <= done_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_q, perr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_q  <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            if (en_rx && state_q == S_PARITY && cnt_q == 4'd8) par_q <= maj_now;
            if (load) perr_q <= (((^shift_q) ^ par_q) != PARITY_ODD);
        end
    end

    assign parity_err = perr_q;
`else
    logic unused_parity_sense;
    assign unused_parity_sense = PARITY_ODD;
    assign parity_err          = 1'b0;
`endif

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_deser.sv
// tb_uart_rx_deser: directed frames against a frame-level model of the receiver, compared every clk.
module tb_uart_rx_deser;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam bit PAR_ODD = 1'b0;

    logic       clk = 1'b0;
    logic       rst, en_rx, rxd, rx_ack;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun, parity_err, busy;

    int total = 0;
    int bad   = 0;
    bit armed = 1'b0;

    // Expected state of the outputs after the next clk edge.
    logic [7:0] m_data;
    logic       m_valid, m_ferr, m_ovr, m_perr, m_busy;

    uart_rx_deser #(.DATA_BITS(8), .SYNC_STAGES(2), .PARITY_ODD(PAR_ODD)) dut (
        .clk(clk), .rst(rst), .en_rx(en_rx), .rxd(rxd),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
        .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (armed)
            chk("outputs", {3'b000, busy, parity_err, overrun, frame_err, rx_valid, rx_data},
                           {3'b000, m_busy, m_perr, m_ovr, m_ferr, m_valid, m_data});
    end

    task automatic model_reset();
        m_data = 8'h00; m_valid = 1'b0; m_ferr = 1'b0;
        m_ovr = 1'b0; m_perr = 1'b0; m_busy = 1'b0;
    endtask

    task automatic model_complete(input logic [7:0] d, input logic stopb, input logic perr,
                                  input logic ack);
        if (!m_valid || ack) begin
            if (m_valid && ack) m_ovr = 1'b0;
            m_data  = d;
            m_ferr  = ~stopb;
            m_perr  = perr;
            m_valid = 1'b1;
        end else begin
            m_ovr = 1'b1;
        end
    endtask

    // One oversample period: rxd held for 4 clks, tick on the last one. Starts and ends at a negedge.
    task automatic slot(input logic v, input int busy_nx);
        rxd   = v;
        en_rx = 1'b0;
        repeat (3) @(negedge clk);
        en_rx = 1'b1;
        if (busy_nx >= 0) m_busy = busy_nx[0];
        @(negedge clk);
        en_rx = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) slot(1'b1, -1);
    endtask

    task automatic ack_pulse();
        rx_ack = 1'b1;
        if (m_valid) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end
        @(negedge clk);
        rx_ack = 1'b0;
    endtask

    // Each line bit lasts 16 slots; the receiver's index k of a bit falls in slot k+1 of that bit.
    task automatic send_frame(input logic [7:0] d, input logic stopb, input logic parb,
                              input int gl_bit, input int gl_off, input logic ack_done,
                              input int max_slots);
        logic [10:0] bits;
        logic        v, perr;
        int          nb, n, bnx;
        bits    = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = d[i];
        nb = 9;
        if (PAR_EN) begin
            bits[9] = parb;
            nb      = 10;
        end
        perr     = PAR_EN && (((^d) ^ parb) != PAR_ODD);
        bits[nb] = stopb;
        nb       = nb + 1;
        n        = 0;
        for (int b = 0; b < nb; b++) begin
            for (int off = 0; off < 16; off++) begin
                if (max_slots >= 0 && n >= max_slots) return;
                v = bits[b];
                if (b == nb - 1 && off > 9) v = 1'b1;
                if (b == gl_bit + 1 && off == gl_off) v = ~v;
                bnx = (b == 0 && off == 0) ? 1 : ((b == nb - 1 && off == 9) ? 0 : -1);
                slot(v, bnx);
                n++;
                if (b == nb - 1 && off == 9) begin
                    rx_ack = ack_done;
                    model_complete(d, stopb, perr, ack_done);
                    @(negedge clk);
                    rx_ack = 1'b0;
                end
            end
        end
    endtask

    initial begin
        rst = 1'b0; en_rx = 1'b0; rxd = 1'b1; rx_ack = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        armed = 1'b1;
        chk("reset_valid", 16'(rx_valid), 16'h0);
        chk("reset_busy",  16'(busy),     16'h0);
        chk("reset_data",  16'(rx_data),  16'h0);
        rst = 1'b1;
        idle(4);

        send_frame(8'hA5, 1'b1, 1'b0, 0, -1, 1'b0, -1);
        chk("a5_data",  16'(rx_data),   16'h00A5);
        chk("a5_ferr",  16'(frame_err), 16'h0);
        chk("a5_valid", 16'(rx_valid),  16'h1);
        ack_pulse();
        chk("a5_acked", 16'(rx_valid),  16'h0);
        idle(4);

        // Low for 4 ticks only: rejected when the start bit is voted at index 8.
        for (int i = 0; i < 16; i++)
            slot((i < 4) ? 1'b0 : 1'b1, (i == 0) ? 1 : ((i == 9) ? 0 : -1));
        chk("false_busy",  16'(busy),     16'h0);
        chk("false_valid", 16'(rx_valid), 16'h0);
        idle(4);

        send_frame(8'hA5, 1'b1, 1'b0, 3, 8, 1'b0, -1);
        chk("glitch_data", 16'(rx_data), 16'h00A5);
        ack_pulse();
        idle(4);

        send_frame(8'h3C, 1'b0, 1'b0, 0, -1, 1'b0, -1);
        chk("badstop_data",  16'(rx_data),   16'h003C);
        chk("badstop_ferr",  16'(frame_err), 16'h1);
        chk("badstop_valid", 16'(rx_valid),  16'h1);
        ack_pulse();
        idle(4);

        send_frame(8'h11, 1'b1, 1'b0, 0, -1, 1'b0, -1);
        idle(4);
        send_frame(8'h22, 1'b1, 1'b0, 0, -1, 1'b0, -1);
        chk("ovr_data",  16'(rx_data),   16'h0011);
        chk("ovr_flag",  16'(overrun),   16'h1);
        chk("ovr_ferr",  16'(frame_err), 16'h0);
        ack_pulse();
        chk("ovr_clr_valid", 16'(rx_valid), 16'h0);
        chk("ovr_clr_flag",  16'(overrun),  16'h0);
        idle(4);

        send_frame(8'h77, 1'b1, 1'b0, 0, -1, 1'b0, -1);
        chk("pre_rst_valid", 16'(rx_valid), 16'h1);
        idle(4);
        send_frame(8'h5A, 1'b1, 1'b0, 0, -1, 1'b0, 53);
        rst = 1'b0;
        model_reset();
        #1;
        chk("midrst_valid", 16'(rx_valid), 16'h0);
        chk("midrst_data",  16'(rx_data),  16'h0);
        chk("midrst_busy",  16'(busy),     16'h0);
        rxd = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        idle(4);
        send_frame(8'h5A, 1'b1, 1'b0, 0, -1, 1'b0, -1);
        chk("after_rst_data", 16'(rx_data),   16'h005A);
        chk("after_rst_ferr", 16'(frame_err), 16'h0);
        idle(4);

        // Overrun set, then a completion landing in the same clk as an ack.
        send_frame(8'hEE, 1'b1, 1'b0, 0, -1, 1'b0, -1);
        chk("ovr2_flag", 16'(overrun), 16'h1);
        idle(4);
        send_frame(8'h33, 1'b1, 1'b0, 0, -1, 1'b1, -1);
        chk("ackdone_data",  16'(rx_data),  16'h0033);
        chk("ackdone_valid", 16'(rx_valid), 16'h1);
        chk("ackdone_ovr",   16'(overrun),  16'h0);
        ack_pulse();
        idle(4);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0, 0, -1, 1'b0, -1);
        chk("par_bad",  16'(parity_err), 16'h1);
        ack_pulse();
        idle(4);
        send_frame(8'h07, 1'b1, 1'b1, 0, -1, 1'b0, -1);
        chk("par_good", 16'(parity_err), 16'h0);
        ack_pulse();
        idle(4);
`else
        chk("par_tied", 16'(parity_err), 16'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
